handshake_const_seq: RTL and testbench

Parametrised successor to the single-constant handshake source. On every accepted control token it emits the next word of a compile-time table of NUM_VALUES constants, in round-robin order. The output is registered and decouples ctrl from outs through an elastic buffer, so the constant path no longer chains combinational valid/ready. It sits in the dataflow fabric wherever a loop or unrolled body needs a per-iteration constant such as coefficients or strides.

---
 rtl/handshake_pkg.sv | 20 ++
 rtl/handshake_elastic_buf.sv | 123 ++++++++++++
 rtl/handshake_const_seq.sv | 73 +++++++
 tb/tb_handshake_const_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// handshake_pkg
//   Shared types and helpers for the handshake constant-sequence source.
//   - buf_state_e : occupancy state of the elastic output buffer.
//                   BUF_FULL aliases BUF_ONE for the single-entry build.
//   - idx_width() : width of a round-robin index over n entries, never below 1.
package handshake_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam buf_state_e BUF_FULL = BUF_ONE;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/handshake_elastic_buf.sv
// handshake_elastic_buf
//   Registered valid/ready buffer between the constant lookup and the consumer.
//   Build option HANDSHAKE_CONST_SEQ_SKID_EN:
//     defined   - two-entry skid buffer, in_ready driven from registered state only
//     undefined - single pipeline register, in_ready passes out_ready through
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   upstream handshake, in_data written on accept
//     out_data/out_valid  registered head token
//     out_ready           downstream accepts the head token
//
//   state      | meaning
//   -----------+---------------------------------------------
//   BUF_EMPTY  | no token held, out_valid low
//   BUF_ONE    | head holds one token (BUF_FULL in single mode)
//   BUF_TWO    | head and skid both hold tokens, in_ready low
module handshake_elastic_buf
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    buf_state_e            state_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic                  valid_q;
    logic                  accept;
    logic                  emit;

    assign accept    = in_valid && in_ready;
    assign emit      = valid_q && out_ready;
    assign out_data  = head_q;
    assign out_valid = valid_q;

`ifdef HANDSHAKE_CONST_SEQ_SKID_EN
    logic [DATA_WIDTH-1:0] skid_q;

    assign in_ready = (state_q != BUF_TWO) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        head_q  <= in_data;
                        valid_q <= 1'b1;
                        state_q <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && emit) begin
                        head_q <= in_data;
                    end else if (accept) begin
                        skid_q  <= in_data;
                        state_q <= BUF_TWO;
                    end else if (emit) begin
                        valid_q <= 1'b0;
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // in_ready is low here, so only the drain case exists
                    if (emit) begin
                        head_q  <= skid_q;
                        state_q <= BUF_ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= BUF_EMPTY;
                end
            endcase
        end
    end
`else
    // A full register can still take a token when the head leaves this cycle.
    assign in_ready = ((state_q == BUF_EMPTY) || out_ready) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        head_q  <= in_data;
                        valid_q <= 1'b1;
                        state_q <= BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    if (accept) begin
                        head_q <= in_data;
                    end else if (emit) begin
                        valid_q <= 1'b0;
                        state_q <= BUF_EMPTY;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= BUF_EMPTY;
                end
            endcase
        end
    end
`endif

endmodule

// File: rtl/handshake_const_seq.sv
// handshake_const_seq
//   Emits the next word of a compile-time constant table, round-robin, for each
//   accepted control token. Output is registered through handshake_elastic_buf.
//   Build option HANDSHAKE_CONST_SEQ_SKID_EN selects the two-entry skid buffer
//   (registered ctrl_ready); otherwise a single register with ready pass-through.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     ctrl_valid/ctrl_ready    control token handshake
//     outs/outs_valid          registered constant token
//     outs_ready               consumer accepts outs
//   Parameters: DATA_WIDTH, NUM_VALUES, VALUES (entry i at [i*DATA_WIDTH +: DATA_WIDTH])
module handshake_const_seq
    import handshake_pkg::*;
#(
    parameter int                                 DATA_WIDTH = 32,
    parameter int                                 NUM_VALUES = 4,
    parameter logic [NUM_VALUES*DATA_WIDTH-1:0]   VALUES     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int IW = idx_width(NUM_VALUES);

    logic [DATA_WIDTH-1:0] table_w [NUM_VALUES];
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         idx_d;
    logic                  accept;

    for (genvar i = 0; i < NUM_VALUES; i++) begin : g_tbl
        assign table_w[i] = VALUES[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign accept = ctrl_valid && ctrl_ready;

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            if (idx_q == IW'(NUM_VALUES - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    handshake_elastic_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ctrl_valid),
        .in_ready  (ctrl_ready),
        .in_data   (table_w[idx_q]),
        .out_data  (outs),
        .out_valid (outs_valid),
        .out_ready (outs_ready)
    );

endmodule

// File: tb/tb_handshake_const_seq.sv
module tb_handshake_const_seq;

    localparam int DW = 27;
    localparam int NV = 3;
    localparam logic [NV*DW-1:0] VALS = {27'h7A1234, 27'h0000FF, 27'h1E84A3};

`ifdef HANDSHAKE_CONST_SEQ_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_valid;
    logic          ctrl_ready;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready;

    handshake_const_seq #(
        .DATA_WIDTH (DW),
        .NUM_VALUES (NV),
        .VALUES     (VALS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    always #10 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] expq[$];
    logic [DW-1:0] table_m [NV];
    int            model_idx = 0;
    int            accepts = 0;
    int            dep_seen = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. Drive at +1, optional outs_ready flip probe at
    // +2..+4, monitor runs at +6, scoreboard push at +7.
    task automatic step(input bit v, input bit r, input bit rs, input bit probe);
        logic alt;
        @(posedge clk);
        #1;
        ctrl_valid = v;
        outs_ready = r;
        rst        = rs;
        #1;
        if (probe) begin
            outs_ready = ~r;
            #1;
            alt = ctrl_ready;
            outs_ready = r;
            #1;
            if (alt !== ctrl_ready) dep_seen++;
        end else begin
            #2;
        end
        #3;
        if (rst) begin
            expq.delete();
            model_idx = 0;
        end else if (ctrl_valid && ctrl_ready) begin
            expq.push_back(table_m[model_idx]);
            model_idx = (model_idx + 1) % NV;
            accepts++;
        end
    endtask

    // Monitor: checks handshake rules against queue occupancy and pops on emit.
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_outs = '0;
    initial begin
        forever begin
            @(posedge clk);
            #6;
            if (mon_en) begin
                if (rst) begin
                    chk("ready_in_rst", 32'(ctrl_ready), 32'd0);
                end else begin
                    chk("outs_valid", 32'(outs_valid), 32'(expq.size() != 0));
                    if (SKID) chk("ctrl_ready", 32'(ctrl_ready), 32'(expq.size() < 2));
                    else      chk("ctrl_ready", 32'(ctrl_ready),
                                  32'((expq.size() == 0) || outs_ready));
                    if (prev_hold) begin
                        chk("no_retract_valid", 32'(outs_valid), 32'd1);
                        chk("no_retract_data", 32'(outs), 32'(prev_outs));
                    end
                    if (outs_valid && outs_ready && expq.size() > 0)
                        chk("data", 32'(outs), 32'(expq.pop_front()));
                end
                prev_hold = !rst && outs_valid && !outs_ready;
                prev_outs = outs;
            end
        end
    end

    initial begin
        table_m[0] = 27'h1E84A3;
        table_m[1] = 27'h0000FF;
        table_m[2] = 27'h7A1234;
        rst = 1'b1;
        ctrl_valid = 1'b1;
        outs_ready = 1'b0;

        step(1, 0, 1, 0);
        mon_en = 1'b1;
        step(1, 0, 1, 0);
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_outs_valid", 32'(outs_valid), 32'd0);

        // streaming
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

        // backpressure from a fresh sequence
        step(0, 0, 1, 0);
        accepts = 0;
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("bp_accepts", 32'(accepts), SKID ? 32'd2 : 32'd1);
        chk("bp_head", 32'(outs), 32'h1E84A3);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

        // sparse control
        for (int i = 0; i < 16; i++) step(i % 4 == 0, 1, 0, 0);

        // reset mid-stream with tokens buffered
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 1, 0, 0);
        chk("post_rst_valid", 32'(outs_valid), 32'd0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("post_rst_first", 32'(outs), 32'h1E84A3);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

        // random valid/ready with ready-path probing
        dep_seen = 0;
        for (int i = 0; i < 10000; i++)
            step(($urandom % 4) != 0, ($urandom % 3) != 0, 0, 1);
        if (SKID) chk("ready_comb_dep", 32'(dep_seen), 32'd0);
        else      chk("ready_comb_dep_seen", 32'(dep_seen > 0), 32'd1);

        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("drain_empty", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
